serial_xfer_ctrl: RTL and testbench

Sequencer for a pair of WIDTH-bit parallel-load/shift registers (A, B) performing a classic serial transfer or serial addition one bit per clock. It owns both registers, a shift counter, the carry flip-flop and a three-state control FSM. It sits beside the parallel register blocks as their shift-control unit, with a start/busy/done handshake to the surrounding logic.

---
 rtl/serial_xfer_ctrl.sv | 119 +++++++++++
 tb/tb_serial_xfer_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_xfer_ctrl.sv
// serial_xfer_ctrl: shift sequencer for registers A and B (serial transfer/add).
// Optional serial adder enabled by defining SERIAL_ADD_EN.
module serial_xfer_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             busy,
    output logic             done,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser;

`ifdef SERIAL_ADD_EN
    logic carry_q, carry_d;
    logic carry_sh;

    // Full adder on the low bits; its sum feeds the top of A
    always_comb begin
        ser      = a_q[0] ^ b_q[0] ^ carry_q;
        carry_sh = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end

    assign cout = carry_q;
`else
    // Plain transfer: B's low bit moves into A
    always_comb begin
        ser = b_q[0];
    end

    assign cout = 1'b0;
`endif

    // Next-state and datapath update for load / shift / hold
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADD_EN
        carry_d = carry_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    cnt_d   = CW'(WIDTH);
`ifdef SERIAL_ADD_EN
                    carry_d = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = {ser, a_q[WIDTH-1:1]};
                b_d   = {b_q[0], b_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
`ifdef SERIAL_ADD_EN
                carry_d = carry_sh;
`endif
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// tb_serial_xfer_ctrl: scoreboard bench for serial_xfer_ctrl.
// Reference results come from integer add / copy; follows SERIAL_ADD_EN.
module tb_serial_xfer_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic [W-1:0] a_out, b_out;
    logic         busy, done, cout;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        int           ep;
    } res_t;

    res_t sb[$];
    res_t pend;
    res_t hold;
    int   model_cnt = 0;
    int   epoch = 0;
    bit   armed = 1'b0;
    int   checks = 0;
    int   failures = 0;

    serial_xfer_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .a_out (a_out),
        .b_out (b_out),
        .busy  (busy),
        .done  (done),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic res_t expect_of(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input int ep);
        res_t r;
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        r.b = b;
        r.ep = ep;
`ifdef SERIAL_ADD_EN
        r.a = s[W-1:0];
        r.c = s[W];
`else
        r.a = b;
        r.c = 1'b0;
`endif
        return r;
    endfunction

    // Reference: an accepted start keeps the block busy for W+1 cycles,
    // the last of which is the done cycle.
    always @(posedge clk) begin
        if (rst) begin
            armed     <= 1'b1;
            epoch     <= epoch + 1;
            model_cnt <= 0;
            hold      <= '{a: '0, b: '0, c: 1'b0, ep: 0};
        end else if (model_cnt == 0) begin
            if (start) begin
                sb.push_back(expect_of(a_in, b_in, epoch));
                pend      <= expect_of(a_in, b_in, epoch);
                model_cnt <= W + 1;
            end
        end else begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 2) hold <= pend;
        end
    end

    // Monitor: handshake every cycle, results on done, hold while idle
    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 32'(busy), 32'(model_cnt != 0));
            chk("done", 32'(done), 32'(model_cnt == 1));
            if (done || model_cnt == 1) begin
                while (sb.size() > 0 && sb[0].ep != epoch) void'(sb.pop_front());
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    chk("done_a", 32'(a_out), 32'(e.a));
                    chk("done_b", 32'(b_out), 32'(e.b));
                    chk("done_cout", 32'(cout), 32'(e.c));
                end
            end else if (model_cnt == 0) begin
                chk("hold_a", 32'(a_out), 32'(hold.a));
                chk("hold_b", 32'(b_out), 32'(hold.b));
                chk("hold_cout", 32'(cout), 32'(hold.c));
            end
`ifndef SERIAL_ADD_EN
            chk("cout_zero", 32'(cout), 32'd0);
`endif
        end
    end

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        op(4'b0011, 4'b0101);
        op(4'b1111, 4'b0001);
        op(4'b1010, 4'b0110);

        // start held high across several operations
        start = 1'b1;
        a_in  = 4'b0001;
        b_in  = 4'b0001;
        repeat (3 * (W + 2)) @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // reset during the second shift cycle
        start = 1'b1;
        a_in  = 4'b1111;
        b_in  = 4'b1111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op(4'b0010, 4'b0011);

        // idle hold
        repeat (20) @(negedge clk);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 2) == 0);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            rst   = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
